// File: rtl/riscv_ex_wb_buffer.sv
// EX-to-WB result buffer: a small circular FIFO that decouples the execute
// stage from write-back. It carries DIFT taint tags and offers register
// forwarding from the stored (not in-flight) entries.
module riscv_ex_wb_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          TAG_EN     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  // EX side
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic                      ex_we_i,
  input  logic [ADDR_WIDTH-1:0]     ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
  input  logic                      ex_tag_a_i,
  input  logic                      ex_tag_b_i,
  input  logic [1:0]                ex_tag_mode_i,
  // WB side
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic                      wb_we_o,
  output logic [ADDR_WIDTH-1:0]     wb_waddr_o,
  output logic [DATA_WIDTH-1:0]     wb_wdata_o,
  output logic                      wb_tag_o,
  // Forwarding lookup
  input  logic [ADDR_WIDTH-1:0]     fwd_raddr_i,
  output logic                      fwd_hit_o,
  output logic [DATA_WIDTH-1:0]     fwd_wdata_o,
  output logic                      fwd_tag_o,
  // Occupancy
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage; only the control state is reset, stale entries are
  // masked by the occupancy counter.
  logic                  we_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr_q [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_q [DEPTH];
  logic                  tag_q   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;
  logic tag_new;
  logic not_empty;

  assign not_empty  = (count_q != '0);
  assign ex_ready_o = (count_q < CntW'(DEPTH));
  assign wb_valid_o = not_empty;
  assign count_o    = count_q;

  // Flush overrides both handshakes so nothing enters or leaves that cycle.
  assign push = ex_valid_i & ex_ready_o & ~flush_i;
  assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

  // Tag propagation rule applied at push time.
  always_comb begin
    tag_new = 1'b0;
    unique case (ex_tag_mode_i)
      2'b00:   tag_new = ex_tag_a_i | ex_tag_b_i;
      2'b01:   tag_new = ex_tag_a_i;
      2'b10:   tag_new = 1'b0;
      default: tag_new = 1'b1;
    endcase
    if (!TAG_EN) tag_new = 1'b0;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write on push; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) begin
      we_q[wr_ptr_q]    <= ex_we_i;
      waddr_q[wr_ptr_q] <= ex_waddr_i;
      wdata_q[wr_ptr_q] <= ex_wdata_i;
      tag_q[wr_ptr_q]   <= tag_new;
    end
  end

  // Head entry presented to WB, forced to zero while empty.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    wb_tag_o   = 1'b0;
    if (not_empty) begin
      wb_we_o    = we_q[rd_ptr_q];
      wb_waddr_o = waddr_q[rd_ptr_q];
      wb_wdata_o = wdata_q[rd_ptr_q];
      wb_tag_o   = tag_q[rd_ptr_q];
    end
  end

  // Forwarding scan from oldest to youngest; a later match overrides, so
  // the youngest writer of the register wins. x0 never forwards.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx         = '0;
    fwd_hit_o   = 1'b0;
    fwd_wdata_o = '0;
    fwd_tag_o   = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) && we_q[idx] && (waddr_q[idx] == fwd_raddr_i) &&
          (fwd_raddr_i != '0)) begin
        fwd_hit_o   = 1'b1;
        fwd_wdata_o = wdata_q[idx];
        fwd_tag_o   = tag_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Bench for riscv_ex_wb_buffer: a DEPTH=2 and a DEPTH=4 instance share one
// stimulus stream; each is tracked by a queue-based reference model.
module tb_riscv_ex_wb_buffer;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        tag;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, ex_valid = 1'b0, ex_we = 1'b0, tag_a = 1'b0, tag_b = 1'b0;
  logic wb_ready = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  ex_waddr = '0, fwd_raddr = '0;
  logic [31:0] ex_wdata = '0;

  logic ready2, wbv2, we2, wtag2, hit2, ftag2;
  logic [4:0] waddr2;
  logic [31:0] wdata2, fdata2;
  logic [1:0] cnt2;
  logic ready4, wbv4, we4, wtag4, hit4, ftag4;
  logic [4:0] waddr4;
  logic [31:0] wdata4, fdata4;
  logic [2:0] cnt4;

  entry_t q2[$];
  entry_t q4[$];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_ex_wb_buffer #(.DATA_WIDTH(32), .DEPTH(2), .ADDR_WIDTH(5), .TAG_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(ready2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_tag_a_i(tag_a),
    .ex_tag_b_i(tag_b), .ex_tag_mode_i(mode), .wb_valid_o(wbv2), .wb_ready_i(wb_ready),
    .wb_we_o(we2), .wb_waddr_o(waddr2), .wb_wdata_o(wdata2), .wb_tag_o(wtag2),
    .fwd_raddr_i(fwd_raddr), .fwd_hit_o(hit2), .fwd_wdata_o(fdata2), .fwd_tag_o(ftag2),
    .count_o(cnt2)
  );

  riscv_ex_wb_buffer #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(5), .TAG_EN(1'b1)) u4 (
    .clk(clk), .rst(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(ready4),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_tag_a_i(tag_a),
    .ex_tag_b_i(tag_b), .ex_tag_mode_i(mode), .wb_valid_o(wbv4), .wb_ready_i(wb_ready),
    .wb_we_o(we4), .wb_waddr_o(waddr4), .wb_wdata_o(wdata4), .wb_tag_o(wtag4),
    .fwd_raddr_i(fwd_raddr), .fwd_hit_o(hit4), .fwd_wdata_o(fdata4), .fwd_tag_o(ftag4),
    .count_o(cnt4)
  );

  function automatic logic model_tag(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   return a | b;
      2'b01:   return a;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Expected {count, ready, valid, we, waddr, wdata, tag, hit, fwd_data, fwd_tag}.
  function automatic logic [77:0] exp_vec(input bit sel4, input logic [4:0] raddr);
    entry_t q[$];
    entry_t h, f;
    int n, depth;
    logic hit, rdy, vld;
    q = sel4 ? q4 : q2;
    depth = sel4 ? 4 : 2;
    n = q.size();
    h = '0;
    f = '0;
    hit = 1'b0;
    if (n > 0) h = q[0];
    for (int i = n - 1; i >= 0; i--) begin
      if (raddr != 0 && q[i].we && q[i].waddr == raddr) begin
        hit = 1'b1;
        f = q[i];
        break;
      end
    end
    rdy = (n < depth);
    vld = (n != 0);
    return {3'(n), rdy, vld, h.we, h.waddr, h.wdata, h.tag, hit, f.wdata, f.tag};
  endfunction

  // Advance one clock edge and apply the same edge to both models.
  task automatic tick();
    entry_t e;
    bit push2, pop2, push4, pop4;
    e = '{we: ex_we, waddr: ex_waddr, wdata: ex_wdata, tag: model_tag(mode, tag_a, tag_b)};
    @(posedge clk);
    if (rst || flush) begin
      q2.delete();
      q4.delete();
    end else begin
      push2 = ex_valid && q2.size() < 2;
      pop2  = wb_ready && q2.size() > 0;
      push4 = ex_valid && q4.size() < 4;
      pop4  = wb_ready && q4.size() > 0;
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(e);
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(e);
    end
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic [1:0] m, input logic ta, input logic tb);
    ex_valid = v; ex_we = 1'b1; ex_waddr = a; ex_wdata = d; mode = m; tag_a = ta; tag_b = tb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    fwd_raddr = 5'd0;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt2); end
    n_cmp++; if (wbv2 !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", wbv2); end
    n_cmp++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ready2); end
    n_cmp++; if ({we2, waddr2, wdata2, wtag2, hit2} !== '0) begin
      n_fail++; $display("FAIL reset_wb_fields: got %h want 0", {we2, waddr2, wdata2, wtag2, hit2});
    end
    n_cmp++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL reset_count4: got %0d want 0", cnt4); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_push_basic();
    set_ex(1'b1, 5'd5, 32'hA5A5_A5A5, 2'b00, 1'b0, 1'b1);
    wb_ready = 1'b0;
    fwd_raddr = 5'd5;
    @(negedge clk);
    n_cmp++; if (wbv2 !== 1'b0) begin n_fail++; $display("FAIL push_latency: got %0b want 0", wbv2); end
    n_cmp++; if (hit2 !== 1'b0) begin n_fail++; $display("FAIL fwd_inflight: got %0b want 0", hit2); end
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (wbv2 !== 1'b1) begin n_fail++; $display("FAIL push_valid: got %0b want 1", wbv2); end
    n_cmp++; if (wdata2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL push_data: got %h want a5a5a5a5", wdata2); end
    n_cmp++; if (wtag2 !== 1'b1) begin n_fail++; $display("FAIL push_tag: got %0b want 1", wtag2); end
    n_cmp++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL push_count: got %0d want 1", cnt2); end
    n_cmp++; if ({we2, waddr2} !== {1'b1, 5'd5}) begin n_fail++; $display("FAIL push_addr: got %h want 25", {we2, waddr2}); end
    n_cmp++; if (hit2 !== 1'b1 || fdata2 !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL fwd_stored: got %0b/%h want 1/a5a5a5a5", hit2, fdata2);
    end
    tick();
  endtask

  task automatic test_full();
    set_ex(1'b1, 5'd6, 32'h2, 2'b10, 1'b1, 1'b1);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", cnt2); end
    n_cmp++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", ready2); end
    tick();
    set_ex(1'b1, 5'd7, 32'h3, 2'b11, 1'b0, 1'b0);
    wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop: got %0b want 0", ready2); end
    tick();
    ex_valid = 1'b0;
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd1 || ready2 !== 1'b1) begin
      n_fail++; $display("FAIL pop_count_ready: got %0d/%0b want 1/1", cnt2, ready2);
    end
    n_cmp++; if ({waddr2, wdata2, wtag2} !== {5'd6, 32'h2, 1'b0}) begin
      n_fail++; $display("FAIL pop_head: got %h want %h", {waddr2, wdata2, wtag2}, {5'd6, 32'h2, 1'b0});
    end
    tick();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd0 || wbv2 !== 1'b0 || wdata2 !== 32'h0) begin
      n_fail++; $display("FAIL full_drop: got %0d/%0b/%h want 0/0/0", cnt2, wbv2, wdata2);
    end
    tick();
  endtask

  task automatic test_forward();
    set_ex(1'b1, 5'd3, 32'h11, 2'b00, 1'b0, 1'b0);
    tick();
    ex_wdata = 32'h22;
    tick();
    ex_valid = 1'b0;
    fwd_raddr = 5'd3;
    @(negedge clk);
    n_cmp++; if (hit2 !== 1'b1 || fdata2 !== 32'h22) begin
      n_fail++; $display("FAIL fwd_youngest: got %0b/%h want 1/22", hit2, fdata2);
    end
    n_cmp++; if (wdata2 !== 32'h11) begin n_fail++; $display("FAIL fwd_head: got %h want 11", wdata2); end
    fwd_raddr = 5'd0;
    #1;
    n_cmp++; if (hit2 !== 1'b0 || fdata2 !== 32'h0) begin
      n_fail++; $display("FAIL fwd_x0: got %0b/%h want 0/0", hit2, fdata2);
    end
    fwd_raddr = 5'd4;
    #1;
    n_cmp++; if (hit2 !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: got %0b want 0", hit2); end
    tick();
  endtask

  task automatic test_flush();
    set_ex(1'b1, 5'd9, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0);
    flush = 1'b1;
    wb_ready = 1'b1;
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    wb_ready = 1'b0;
    fwd_raddr = 5'd9;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd0 || wbv2 !== 1'b0 || cnt4 !== 3'd0) begin
      n_fail++; $display("FAIL flush_count: got %0d/%0b/%0d want 0/0/0", cnt2, wbv2, cnt4);
    end
    n_cmp++; if (wdata2 !== 32'h0 || hit2 !== 1'b0) begin
      n_fail++; $display("FAIL flush_dropped: got %h/%0b want 0/0", wdata2, hit2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 5'(k + 1), 32'h100 + k, 2'b00, 1'b0, 1'b0);
      tick();
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_ex(1'b1, 5'(c + 3), 32'h102 + c, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (cnt4 !== 3'd2 || wdata4 !== 32'h100 + c) begin
        n_fail++; $display("FAIL wrap_order[%0d]: got %0d/%h want 2/%h", c, cnt4, wdata4, 32'h100 + c);
      end
      tick();
    end
    ex_valid = 1'b0;
    wb_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_ex(1'b1, 5'd8, 32'h55, 2'b00, 1'b1, 1'b0);
    tick();
    ex_valid = 1'b0;
    fwd_raddr = 5'd8;
    @(negedge clk);
    n_cmp++; if (cnt2 !== 2'd1 || wtag2 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got %0d/%0b want 1/1", cnt2, wtag2);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({cnt2, wbv2, we2, waddr2, wdata2, wtag2, hit2} !== '0 || ready2 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got %h/%0b want 0/1",
                         {cnt2, wbv2, we2, waddr2, wdata2, wtag2, hit2}, ready2);
    end
    tick();
    rst = 1'b0;
    set_ex(1'b1, 5'd2, 32'h77, 2'b11, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (wbv2 !== 1'b1 || wtag2 !== 1'b1 || wdata2 !== 32'h77 || cnt2 !== 2'd1) begin
      n_fail++; $display("FAIL post_reset_push: got %0b/%0b/%h/%0d want 1/1/77/1", wbv2, wtag2, wdata2, cnt2);
    end
    tick();
  endtask

  task automatic test_random();
    logic [77:0] exp2, exp4, act2, act4;
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(15) == 0);
      ex_valid  = ($urandom_range(9) < 6);
      ex_we     = ($urandom_range(3) != 0);
      ex_waddr  = 5'($urandom_range(7));
      ex_wdata  = $urandom;
      tag_a     = 1'($urandom);
      tag_b     = 1'($urandom);
      mode      = 2'($urandom);
      wb_ready  = 1'($urandom);
      fwd_raddr = 5'($urandom_range(7));
      @(negedge clk);
      exp2 = exp_vec(1'b0, fwd_raddr);
      exp4 = exp_vec(1'b1, fwd_raddr);
      act2 = {1'b0, cnt2, ready2, wbv2, we2, waddr2, wdata2, wtag2, hit2, fdata2, ftag2};
      act4 = {cnt4, ready4, wbv4, we4, waddr4, wdata4, wtag4, hit4, fdata4, ftag4};
      n_cmp++; if (act2 !== exp2) begin n_fail++; $display("FAIL rand_d2[%0d]: got %h want %h", i, act2, exp2); end
      n_cmp++; if (act4 !== exp4) begin n_fail++; $display("FAIL rand_d4[%0d]: got %h want %h", i, act4, exp4); end
      tick();
    end
    flush = 1'b0;
    ex_valid = 1'b0;
    wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full();
    test_forward();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
